regwriteback: RTL and testbench



---
 rtl/regwb_pkg.sv | 15 +
 rtl/regwriteback_if.sv | 47 ++++
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/regwriteback.sv | 88 ++++++++
 tb/tb_regwriteback.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register write-back queue.
package regwb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Writes to r0 are architecturally discarded
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regwriteback_if.sv
// Bundle of producer handshakes, bank write port, hazard query and status for regwriteback.
interface regwriteback_if
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;

    logic              aluValid;
    logic [ADDR_W-1:0] aluRd;
    logic [DATA_W-1:0] aluData;
    logic              aluReady;

    logic              memValid;
    logic [ADDR_W-1:0] memRd;
    logic [DATA_W-1:0] memData;
    logic              memReady;

    logic              wrReg;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] rdIn;

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rsBusy;
    logic              rtBusy;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    // Pipeline side: drives results, flush and decode queries
    modport master (
        output flush, aluValid, aluRd, aluData, memValid, memRd, memData, rs, rt,
        input  aluReady, memReady, wrReg, rd, rdIn, rsBusy, rtBusy, count, full, empty
    );

    // Write-back queue side
    modport slave (
        input  flush, aluValid, aluRd, aluData, memValid, memRd, memData, rs, rt,
        output aluReady, memReady, wrReg, rd, rdIn, rsBusy, rtBusy, count, full, empty
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer with up to two pushes and one pop per cycle.
// push_b implies push_a; entry_a lands at tail and entry_b at tail+1.
module wb_fifo
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_a,
    input  wb_entry_t        entry_a,
    input  logic             push_b,
    input  wb_entry_t        entry_b,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic [DEPTH-1:0] occupied,
    output wb_entry_t        slots [DEPTH]
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_plus1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] off;
    logic             pop_eff;

    assign tail_plus1 = tail_q + PTR_W'(1);
    assign pop_eff    = pop && (count_q != '0);

    // Pointer and occupancy next-state; flush overrides all traffic
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_eff) head_d = head_q + PTR_W'(1);
            if (push_b) tail_d = tail_q + PTR_W'(2);
            else if (push_a) tail_d = tail_plus1;
            count_d = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop_eff);
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; unreset since occupancy masks stale slots
    always_ff @(posedge clk) begin
        if (push_a && !flush) mem_q[tail_q] <= entry_a;
        if (push_b && !flush) mem_q[tail_plus1] <= entry_b;
    end

    // Slot i is live when its distance from head is below the count
    always_comb begin
        occupied = '0;
        off      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off         = PTR_W'(i) - head_q;
            occupied[i] = ({1'b0, off} < count_q);
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;
    assign slots = mem_q;

endmodule

// File: rtl/regwriteback.sv
// Write-back queue: arbitrates ALU/load results into a FIFO drained onto the register bank.
module regwriteback
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    regwriteback_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             mem_ready, alu_ready;
    logic             mem_push, alu_push;
    logic             push_a, push_b;
    wb_entry_t        mem_entry, alu_entry, entry_a, head;
    wb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] occupied;
    logic             empty;
    logic             rs_busy, rt_busy;

    // Credit comes from registered count only, so ready never depends on the drain
    assign free      = CNT_W'(DEPTH) - count;
    assign mem_ready = (free >= CNT_W'(1));
    assign alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !bus.memValid);

    assign mem_entry = '{rd: bus.memRd, data: bus.memData};
    assign alu_entry = '{rd: bus.aluRd, data: bus.aluData};

    // r0 handshakes complete but are never stored
    assign mem_push = bus.memValid && mem_ready && (bus.memRd != REG_ZERO);
    assign alu_push = bus.aluValid && alu_ready && (bus.aluRd != REG_ZERO);

    // Load is older, so it takes the first slot when both push
    assign push_a  = mem_push || alu_push;
    assign push_b  = mem_push && alu_push;
    assign entry_a = mem_push ? mem_entry : alu_entry;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (alu_entry),
        .pop     (!empty),
        .head    (head),
        .count   (count),
        .occupied(occupied),
        .slots   (slots)
    );

    assign empty = (count == '0);

    // Hazard scoreboard over live entries; r0 is never busy
    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (occupied[i] && (slots[i].rd == bus.rs)) rs_busy = 1'b1;
            if (occupied[i] && (slots[i].rd == bus.rt)) rt_busy = 1'b1;
        end
        rs_busy = rs_busy && (bus.rs != REG_ZERO);
        rt_busy = rt_busy && (bus.rt != REG_ZERO);
    end

    // Bank write port: head is written every cycle the queue is non-empty
    always_comb begin
        bus.wrReg = !empty;
        bus.rd    = empty ? '0 : head.rd;
        bus.rdIn  = empty ? '0 : head.data;
    end

    assign bus.aluReady = alu_ready;
    assign bus.memReady = mem_ready;
    assign bus.rsBusy   = rs_busy;
    assign bus.rtBusy   = rt_busy;
    assign bus.count    = count;
    assign bus.full     = (count == CNT_W'(DEPTH));
    assign bus.empty    = empty;

endmodule

// File: tb/tb_regwriteback.sv
// Directed self-checking bench for regwriteback (DEPTH=4).
module tb_regwriteback;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regwriteback_if #(.DEPTH(4)) bus ();

    regwriteback #(
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.aluValid = 1'b0;
        bus.aluRd    = '0;
        bus.aluData  = '0;
        bus.memValid = 1'b0;
        bus.memRd    = '0;
        bus.memData  = '0;
    endtask

    task automatic offer(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
        bus.memValid = mv;
        bus.memRd    = mrd;
        bus.memData  = md;
        bus.aluValid = av;
        bus.aluRd    = ard;
        bus.aluData  = ad;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        bus.rs = '0;
        bus.rt = '0;

        // Reset state
        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_wrreg", 32'(bus.wrReg), 32'd0);
        chk("rst_rd", 32'(bus.rd), 32'd0);
        chk("rst_rdin", bus.rdIn, 32'd0);
        chk("rst_rsbusy", 32'(bus.rsBusy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_aluready", 32'(bus.aluReady), 32'd1);
        chk("idle_memready", 32'(bus.memReady), 32'd1);

        // Single ALU push
        offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        bus.rs = 5'd7;
        #1;
        chk("single_aluready", 32'(bus.aluReady), 32'd1);
        tick();
        idle();
        #1;
        chk("single_wrreg", 32'(bus.wrReg), 32'd1);
        chk("single_rd", 32'(bus.rd), 32'd7);
        chk("single_rdin", bus.rdIn, 32'h1234);
        chk("single_rsbusy", 32'(bus.rsBusy), 32'd1);
        chk("single_count", 32'(bus.count), 32'd1);
        tick();
        #1;
        chk("single_empty", 32'(bus.empty), 32'd1);
        chk("single_wrreg_off", 32'(bus.wrReg), 32'd0);
        chk("single_rsbusy_off", 32'(bus.rsBusy), 32'd0);

        // Dual push: load is older
        offer(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
        #1;
        chk("dual_memready", 32'(bus.memReady), 32'd1);
        chk("dual_aluready", 32'(bus.aluReady), 32'd1);
        tick();
        idle();
        #1;
        chk("dual_count", 32'(bus.count), 32'd2);
        chk("dual_rd0", 32'(bus.rd), 32'd3);
        chk("dual_rdin0", bus.rdIn, 32'hAA);
        tick();
        #1;
        chk("dual_rd1", 32'(bus.rd), 32'd4);
        chk("dual_rdin1", bus.rdIn, 32'hBB);
        tick();
        #1;
        chk("dual_empty", 32'(bus.empty), 32'd1);

        // Last-slot priority: two dual pushes leave count=3
        offer(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        tick();
        offer(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h55);
        #1;
        chk("fill_aluready_free2", 32'(bus.aluReady), 32'd1);
        tick();
        offer(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
        bus.rs = 5'd6;
        bus.rt = 5'd8;
        #1;
        chk("last_count", 32'(bus.count), 32'd3);
        chk("last_memready", 32'(bus.memReady), 32'd1);
        chk("last_aluready", 32'(bus.aluReady), 32'd0);
        chk("last_full", 32'(bus.full), 32'd0);
        chk("last_head", 32'(bus.rd), 32'd2);
        tick();
        idle();
        #1;
        chk("last_count_after", 32'(bus.count), 32'd3);
        chk("last_rd_after", 32'(bus.rd), 32'd3);
        chk("last_rsbusy_load", 32'(bus.rsBusy), 32'd1);
        chk("last_rtbusy_alu", 32'(bus.rtBusy), 32'd0);
        tick();
        #1;
        chk("drain_rd5", 32'(bus.rd), 32'd5);
        chk("drain_rdin5", bus.rdIn, 32'h55);
        tick();
        #1;
        chk("drain_rd6", 32'(bus.rd), 32'd6);
        tick();
        #1;
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // r0 discard
        offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        #1;
        chk("r0_aluready", 32'(bus.aluReady), 32'd1);
        tick();
        idle();
        #1;
        chk("r0_count", 32'(bus.count), 32'd0);
        chk("r0_wrreg", 32'(bus.wrReg), 32'd0);
        chk("r0_rsbusy", 32'(bus.rsBusy), 32'd0);

        // Load to r0 alongside an ALU result: only the ALU entry is kept
        offer(1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 32'h9999);
        tick();
        idle();
        #1;
        chk("r0mix_count", 32'(bus.count), 32'd1);
        chk("r0mix_rd", 32'(bus.rd), 32'd9);
        chk("r0mix_rdin", bus.rdIn, 32'h9999);
        tick();

        // Flush after pointers have wrapped
        offer(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
        tick();
        offer(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
        tick();
        offer(1'b1, 5'd14, 32'hE0, 1'b0, 5'd0, 32'h0);
        bus.flush = 1'b1;
        bus.rs    = 5'd12;
        bus.rt    = 5'd13;
        #1;
        chk("flush_count_pre", 32'(bus.count), 32'd3);
        chk("flush_head_wr", 32'(bus.wrReg), 32'd1);
        chk("flush_head_rd", 32'(bus.rd), 32'd11);
        chk("flush_memready", 32'(bus.memReady), 32'd1);
        chk("flush_rsbusy_pre", 32'(bus.rsBusy), 32'd1);
        tick();
        idle();
        bus.rs = 5'd14;
        #1;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_wrreg", 32'(bus.wrReg), 32'd0);
        chk("flush_rsbusy", 32'(bus.rsBusy), 32'd0);
        chk("flush_rtbusy", 32'(bus.rtBusy), 32'd0);

        // Asynchronous reset mid-drain with 3 entries queued
        offer(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210);
        tick();
        offer(1'b1, 5'd22, 32'h220, 1'b1, 5'd23, 32'h230);
        tick();
        idle();
        #1;
        chk("prerst_count", 32'(bus.count), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_wrreg", 32'(bus.wrReg), 32'd0);
        chk("arst_rd", 32'(bus.rd), 32'd0);
        chk("arst_rdin", bus.rdIn, 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_empty", 32'(bus.empty), 32'd1);
        chk("postrst_aluready", 32'(bus.aluReady), 32'd1);
        tick();
        #1;
        chk("postrst_wrreg", 32'(bus.wrReg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
